div8bit: RTL and testbench



---
 rtl/div8bit.sv | 160 ++++++++++++++++
 tb/tb_div8bit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div8bit.sv
// div8bit: 8-bit restoring divider, 10-cycle start-to-done latency.
// Define DIV8BIT_SIGNED_EN for two's-complement operands.
module div8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] Dividend,
  input  logic [7:0] Divisor,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic       busy,
  output logic       done,
  output logic       DZ,
  output logic       O
);

  typedef enum logic [1:0] {
    IDLE, RUN, FIX, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] quo_q, quo_d;
  logic [7:0] dvs_q, dvs_d;
  logic [7:0] q_q, q_d;
  logic [7:0] r_q, r_d;
  logic       dz_q, dz_d;
  logic       o_q, o_d;

  logic [7:0] dd_mag, dv_mag;
  logic [7:0] fix_q, fix_r;
  logic       fix_o;
  logic [8:0] sh, trial;
  logic       no_borrow;

`ifdef DIV8BIT_SIGNED_EN
  logic ndd_q, ndv_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ndd_q <= 1'b0;
      ndv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      ndd_q <= Dividend[7];
      ndv_q <= Divisor[7];
      ovf_q <= (Dividend == 8'h80) &&
               (Divisor == 8'hFF);
    end
  end

  always_comb begin
    dd_mag = Dividend[7] ? ~Dividend + 8'd1
                         : Dividend;
    dv_mag = Divisor[7] ? ~Divisor + 8'd1
                        : Divisor;
    fix_q  = (ndd_q ^ ndv_q) ? ~quo_q + 8'd1
                             : quo_q;
    fix_r  = ndd_q ? ~rem_q + 8'd1 : rem_q;
    fix_o  = ovf_q;
  end
`else
  always_comb begin
    dd_mag = Dividend;
    dv_mag = Divisor;
    fix_q  = quo_q;
    fix_r  = rem_q;
    fix_o  = 1'b0;
  end
`endif

  // sh[8] set means the shifted remainder already exceeds any divisor
  always_comb begin
    sh        = {rem_q, quo_q[7]};
    trial     = {1'b0, sh[7:0]} + {1'b0, ~dvs_q}
              + 9'd1;
    no_borrow = sh[8] | trial[8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    o_d     = o_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dz_d  = 1'b0;
          o_d   = 1'b0;
          dvs_d = dv_mag;
          if (Divisor == 8'd0) begin
            state_d = DONE;
            q_d     = 8'hFF;
            r_d     = Dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = 3'd0;
            rem_d   = 8'd0;
            quo_d   = dd_mag;
          end
        end
      end
      RUN: begin
        rem_d = no_borrow ? trial[7:0] : sh[7:0];
        quo_d = {quo_q[6:0], no_borrow};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = FIX;
      end
      FIX: begin
        q_d     = fix_q;
        r_d     = fix_r;
        o_d     = fix_o;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rem_q   <= 8'd0;
      quo_q   <= 8'd0;
      dvs_q   <= 8'd0;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
      dz_q    <= 1'b0;
      o_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      o_q     <= o_d;
    end
  end

  // a divide-by-zero passes straight to DONE without raising busy
  assign busy = (state_q == RUN) ||
                (state_q == FIX) ||
                (state_q == DONE && !dz_q);
  assign done = (state_q == DONE);
  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;
  assign O    = o_q;

endmodule

// File: tb/tb_div8bit.sv
// tb_div8bit: directed and random checks of div8bit
// against an arithmetic reference model.
module tb_div8bit;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] Dividend, Divisor;
  logic [7:0] Q, R;
  logic       busy, done, DZ, O;

  int n_vec = 0;
  int n_err = 0;

  div8bit dut (
    .clk(clk), .rst(rst), .start(start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Q(Q), .R(R), .busy(busy), .done(done),
    .DZ(DZ), .O(O)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input  logic [7:0] a, b,
                       output logic [7:0] q, r,
                       output logic dz, o);
    int sa, sb;
    dz = 1'b0;
    o  = 1'b0;
    if (b == 8'd0) begin
      q  = 8'hFF;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef DIV8BIT_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q = 8'h80;
        r = 8'h00;
        o = 1'b1;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
`else
      sa = int'(a);
      sb = int'(b);
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
`endif
    end
  endtask

  // Called at a negedge; returns at the negedge after
  // the DONE->IDLE edge, so a following call is back-to-back.
  task automatic run_op(input logic [7:0] a, b,
                        input bit hold,
                        output time t0);
    logic [7:0] eq, er;
    logic       edz, eo;
    int         cyc, bc;
    model(a, b, eq, er, edz, eo);
    Dividend = a;
    Divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    if (!hold) start = 1'b0;
    cyc = 0;
    bc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bc++;
    end while (done !== 1'b1 && cyc < 20);
    start = 1'b0;
    chk("latency", cyc, edz ? 1 : 10);
    chk("busy_cycles", bc, edz ? 0 : 10);
    chk("Q", Q, eq);
    chk("R", R, er);
    chk("DZ", DZ, edz);
    chk("O", O, eo);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    time t1, t2;
    int  nd;
    logic [7:0] ra, rb;
    rst      = 1'b1;
    start    = 1'b0;
    Dividend = 8'd0;
    Divisor  = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_Q", Q, 0);
    chk("rst_R", R, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_DZ", DZ, 0);
    chk("rst_O", O, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd100, 8'd7, 1'b0, t1);
    chk("q_100_7", Q, 14);

    run_op(8'd255, 8'd1, 1'b0, t1);
    run_op(8'd200, 8'd255, 1'b0, t2);
    chk("b2b_period", 32'(t2 - t1), 110);
    chk("r_200_255", R, 200);

    run_op(8'd5, 8'd0, 1'b0, t1);

    run_op(8'd77, 8'd9, 1'b1, t1);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("no_requeue", nd, 0);

    Dividend = 8'd50;
    Divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_Q", Q, 0);
    chk("abort_R", R, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_DZ", DZ, 0);
    chk("abort_O", O, 0);
    rst = 1'b0;
    nd  = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_op(8'd50, 8'd3, 1'b0, t1);

    run_op(8'h9C, 8'd7, 1'b0, t1);
    run_op(8'h80, 8'hFF, 1'b0, t1);
    run_op(8'h80, 8'h01, 1'b0, t1);
    run_op(8'h7F, 8'h80, 1'b0, t1);

    repeat (40) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0
                                        : 8'($urandom);
      run_op(ra, rb, 1'b0, t1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
